// File: rtl/sys_array_result_drain_if.sv
// Element stream from the result drain: one matrix element per valid/ready beat with its row/col index.
// Master holds data/row/col/last stable while out_valid is high and out_ready is low.
interface sys_array_result_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 5,
    parameter int ARRAY_A_L  = 6
);
    localparam int ROW_W = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
    localparam int COL_W = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;

    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   out_data;
    logic [ROW_W-1:0]          out_row;
    logic [COL_W-1:0]          out_col;
    logic                      out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/sys_array_result_drain.sv
// Captures the result matrix on a comp_ready rising edge and streams it row-major, one element per beat.
// Latency: element [0][0] valid the cycle after capture; stalls hold outputs; edges while streaming are dropped (overrun).
module sys_array_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 5,
    parameter int ARRAY_A_L  = 6
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic                                                 comp_ready,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] in_data,
    sys_array_result_drain_if.master                             out_if,
    output logic                                                 busy,
    output logic                                                 overrun,
    input  logic                                                 clear_overrun,
    output logic [15:0]                                          frame_count
);
    localparam int ROW_W = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
    localparam int COL_W = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_W_W - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ARRAY_A_L - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             comp_ready_q;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] frame_q;

    logic cap, streaming, at_last, beat, last_beat, load, drop;

    always_comb begin
        cap       = comp_ready & ~comp_ready_q;
        streaming = (state_q == STREAM);
        at_last   = streaming && (row_q == ROW_LAST) && (col_q == COL_LAST);
        beat      = streaming & out_if.out_ready;
        last_beat = beat & at_last;
        // A capture landing on the final beat refills the buffer with no idle bubble.
        load      = cap & (~streaming | last_beat);
        drop      = cap & streaming & ~last_beat;
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_count_d = last_beat ? frame_count_q + 16'd1 : frame_count_q;
        overrun_d     = drop ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);

        if (load) begin
            state_d = STREAM;
            row_d   = '0;
            col_d   = '0;
        end else if (beat) begin
            if (at_last) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            comp_ready_q  <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
            frame_q       <= '0;
        end else begin
            state_q       <= state_d;
            comp_ready_q  <= comp_ready;
            row_q         <= row_d;
            col_q         <= col_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            if (load) begin
                frame_q <= in_data;
            end
        end
    end

    // Outputs derive from registers only, so an async reset clears them immediately.
    always_comb begin
        out_if.out_valid = streaming;
        out_if.out_data  = streaming ? frame_q[row_q][col_q] : '0;
        out_if.out_row   = row_q;
        out_if.out_col   = col_q;
        out_if.out_last  = at_last;
        busy             = streaming;
        overrun          = overrun_q;
        frame_count      = frame_count_q;
    end
endmodule

// File: tb/tb_sys_array_result_drain.sv
// Bench for sys_array_result_drain: frame-level reference model plus scenario tasks.
module tb_sys_array_result_drain;
    localparam int DW = 8;
    localparam int WW = 5;
    localparam int AL = 6;
    localparam int N  = WW * AL;

    typedef struct packed {
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
        logic [15:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic comp_ready = 1'b0;
    logic clear_overrun = 1'b0;
    logic [0:WW-1][0:AL-1][15:0] in_data = '0;
    logic busy, overrun;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail = 0;

    sys_array_result_drain_if #(.DATA_WIDTH(DW), .ARRAY_W_W(WW), .ARRAY_A_L(AL)) ifc ();

    sys_array_result_drain #(.DATA_WIDTH(DW), .ARRAY_W_W(WW), .ARRAY_A_L(AL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .comp_ready    (comp_ready),
        .in_data       (in_data),
        .out_if        (ifc.master),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a block of N pending elements; an edge is taken only when nothing
    // is pending or the last pending element leaves on that same edge, otherwise it is an overrun.
    int          pending;
    logic        prev_cr;
    logic        mdl_ovr;
    logic [15:0] mdl_fc;
    beat_t       exp_q[$];
    beat_t       got_q[$];

    wire mdl_cap    = comp_ready && !prev_cr;
    wire mdl_beat   = (pending > 0) && ifc.out_ready;
    wire mdl_lastb  = mdl_beat && (pending == 1);
    wire mdl_accept = mdl_cap && ((pending == 0) || mdl_lastb);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 0;
            prev_cr <= 1'b0;
            mdl_ovr <= 1'b0;
            mdl_fc  <= '0;
        end else begin
            prev_cr <= comp_ready;
            if (mdl_lastb) mdl_fc <= mdl_fc + 16'd1;
            if (mdl_accept) begin
                pending <= N;
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back('{row: 3'(k / AL), col: 3'(k % AL), last: (k == N - 1),
                                      data: in_data[k / AL][k % AL]});
                end
            end else if (mdl_beat) begin
                pending <= pending - 1;
            end
            if (mdl_cap && !mdl_accept) mdl_ovr <= 1'b1;
            else if (clear_overrun) mdl_ovr <= 1'b0;
        end
    end

    // Recorder: accepted beats plus any output change while stalled.
    int    stall_changes = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_out;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!ifc.out_valid ||
                prev_out !== {ifc.out_row, ifc.out_col, ifc.out_last, ifc.out_data}))
                stall_changes <= stall_changes + 1;
            if (ifc.out_valid && ifc.out_ready)
                got_q.push_back('{row: ifc.out_row, col: ifc.out_col, last: ifc.out_last, data: ifc.out_data});
            prev_stall <= ifc.out_valid && !ifc.out_ready;
            prev_out   <= {ifc.out_row, ifc.out_col, ifc.out_last, ifc.out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [15:0] base);
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < AL; c++)
                in_data[r][c] = base + 16'(16 * r + c);
    endtask

    task automatic set_random_frame();
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < AL; c++)
                in_data[r][c] = 16'($urandom);
    endtask

    task automatic pulse();
        comp_ready = 1'b1;
        tick();
        comp_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        comp_ready = 1'b0;
        clear_overrun = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
        stall_changes = 0;
    endtask

    function automatic int seq_errors();
        int e = 0;
        if (got_q.size() != exp_q.size()) e++;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            if (got_q[k] !== exp_q[k]) e++;
        return e;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({ifc.out_valid, ifc.out_last, busy, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", {ifc.out_valid, ifc.out_last, busy, overrun});
        end
        n_checks++;
        if ({ifc.out_data, ifc.out_row, ifc.out_col, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values data=%h row=%0d col=%0d fc=%0d exp all 0",
                     ifc.out_data, ifc.out_row, ifc.out_col, frame_count);
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        do_reset();
        set_frame(16'h0000);
        ifc.out_ready = 1'b1;
        pulse();
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_latency valid=%b data=%h exp valid=1 data=0000", ifc.out_valid, ifc.out_data);
        end
        for (int i = 0; i < N + 5; i++) tick();
        for (int k = 0; k < got_q.size(); k++)
            if (got_q[k].data !== 16'(16 * (k / AL) + k % AL) || got_q[k].row !== 3'(k / AL) ||
                got_q[k].col !== 3'(k % AL) || got_q[k].last !== (k == N - 1)) bad++;
        n_checks++;
        if (got_q.size() != N || bad != 0) begin
            n_fail++;
            $display("FAIL basic_sequence beats=%0d bad=%0d exp beats=%0d bad=0", got_q.size(), bad, N);
        end
        n_checks++;
        if (frame_count !== 16'd1 || ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end fc=%0d valid=%b busy=%b exp fc=1 valid=0 busy=0",
                     frame_count, ifc.out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_frame(16'h0000);
        ifc.out_ready = 1'b1;
        comp_ready = 1'b1;
        for (int i = 0; i < 4 * N + 8; i++) begin
            tick();
            comp_ready = 1'b0;
            ifc.out_ready = (i % 4 == 0) || (i % 4 == 3);
        end
        n_checks++;
        if (seq_errors() != 0 || got_q.size() != N) begin
            n_fail++;
            $display("FAIL bp_sequence errs=%0d beats=%0d exp errs=0 beats=%0d", seq_errors(), got_q.size(), N);
        end
        n_checks++;
        if (stall_changes != 0) begin
            n_fail++;
            $display("FAIL bp_stable changes=%0d exp 0", stall_changes);
        end
        n_checks++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_count fc=%0d exp 1", frame_count);
        end
    endtask

    task automatic test_overrun();
        int bad = 0;
        do_reset();
        set_frame(16'h0000);
        ifc.out_ready = 1'b1;
        pulse();
        for (int i = 0; i < 40 && got_q.size() < 10; i++) tick();
        set_random_frame();
        pulse();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_rise got=%b exp 1", overrun);
        end
        for (int i = 0; i < N; i++) tick();
        for (int k = 0; k < got_q.size(); k++)
            if (got_q[k].data !== 16'(16 * (k / AL) + k % AL)) bad++;
        n_checks++;
        if (got_q.size() != N || bad != 0 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL overrun_frame beats=%0d bad=%0d fc=%0d exp beats=%0d bad=0 fc=1",
                     got_q.size(), bad, frame_count, N);
        end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear got=%b exp 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_frame(16'h0000);
        ifc.out_ready = 1'b1;
        pulse();
        for (int i = 0; i < 2 * N && !(ifc.out_valid && ifc.out_last); i++) tick();
        n_checks++;
        if (!(ifc.out_valid && ifc.out_last)) begin
            n_fail++;
            $display("FAIL b2b_last_seen got=0 exp 1");
        end
        set_frame(16'h0100);
        pulse();
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h0100 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_next valid=%b data=%h ovr=%b exp valid=1 data=0100 ovr=0",
                     ifc.out_valid, ifc.out_data, overrun);
        end
        for (int i = 0; i < N + 4; i++) tick();
        n_checks++;
        if (frame_count !== 16'd2 || seq_errors() != 0 || got_q.size() != 2 * N || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end fc=%0d errs=%0d beats=%0d ovr=%b exp fc=2 errs=0 beats=%0d ovr=0",
                     frame_count, seq_errors(), got_q.size(), overrun, 2 * N);
        end
    endtask

    task automatic test_level();
        do_reset();
        set_frame(16'h0200);
        ifc.out_ready = 1'b1;
        comp_ready = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        comp_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (frame_count !== 16'd1 || got_q.size() != N || seq_errors() != 0) begin
            n_fail++;
            $display("FAIL level_once fc=%0d beats=%0d exp fc=1 beats=%0d", frame_count, got_q.size(), N);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_frame(16'h0000);
        ifc.out_ready = 1'b1;
        pulse();
        for (int i = 0; i < N + 2; i++) tick();
        pulse();
        for (int i = 0; i < 3; i++) tick();
        pulse();
        for (int i = 0; i < 40 && got_q.size() < N + 7; i++) tick();
        n_checks++;
        if (overrun !== 1'b1 || frame_count !== 16'd1 || ifc.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre ovr=%b fc=%0d valid=%b exp 1 1 1", overrun, frame_count, ifc.out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.out_valid, ifc.out_last, busy, overrun, ifc.out_data, ifc.out_row, ifc.out_col, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async valid=%b last=%b busy=%b ovr=%b data=%h row=%0d col=%0d fc=%0d exp all 0",
                     ifc.out_valid, ifc.out_last, busy, overrun, ifc.out_data, ifc.out_row, ifc.out_col, frame_count);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        n_checks++;
        if (got_q.size() != N + 7 || ifc.out_valid !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_quiet beats=%0d valid=%b fc=%0d exp beats=%0d valid=0 fc=0",
                     got_q.size(), ifc.out_valid, frame_count, N + 7);
        end
    endtask

    task automatic test_random();
        int vbad = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            clear_overrun = ($urandom_range(0, 31) == 0);
            if (comp_ready) comp_ready = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 24) == 0) begin
                set_random_frame();
                comp_ready = 1'b1;
            end
            tick();
            if (ifc.out_valid !== (pending != 0) || busy !== (pending != 0) || overrun !== mdl_ovr) vbad++;
        end
        comp_ready = 1'b0;
        clear_overrun = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < N + 4; i++) tick();
        n_checks++;
        if (vbad != 0) begin
            n_fail++;
            $display("FAIL rand_status bad_cycles=%0d exp 0", vbad);
        end
        n_checks++;
        if (seq_errors() != 0) begin
            n_fail++;
            $display("FAIL rand_sequence errs=%0d got_beats=%0d exp_beats=%0d", seq_errors(), got_q.size(), exp_q.size());
        end
        n_checks++;
        if (frame_count !== mdl_fc || overrun !== mdl_ovr || stall_changes != 0) begin
            n_fail++;
            $display("FAIL rand_end fc=%0d ovr=%b stall=%0d exp fc=%0d ovr=%b stall=0",
                     frame_count, overrun, stall_changes, mdl_fc, mdl_ovr);
        end
    endtask

    initial begin
        ifc.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_level();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sys_array_result_drain.md
# sys_array_result_drain

Downstream stage of `sys_array_fetcher`. Captures the full result matrix when the fetcher raises `ready`, then streams it out one element per beat on a valid/ready interface, row-major. It decouples the array from a narrow consumer (memory writer, UART, next layer) and flags results lost because the consumer was too slow.

## Interface
Parameters:
- `DATA_WIDTH`, 8: operand width; result elements are `2*DATA_WIDTH` bits.
- `ARRAY_W_W`, 5: result rows; matches fetcher `ARRAY_W_W`.
- `ARRAY_A_L`, 6: result columns; matches fetcher `ARRAY_A_L`.

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `comp_ready`  in  1  fetcher `ready`; rising edge marks a valid result matrix.
- `in_data`  in  `[0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0]`  fetcher `out_data`.
- `out_valid`  out  1  current element valid.
- `out_ready`  in  1  consumer accepts element when high with `out_valid`.
- `out_data`  out  `2*DATA_WIDTH`  current element.
- `out_row`  out  `$clog2(ARRAY_W_W)` (min 1)  row index of `out_data`.
- `out_col`  out  `$clog2(ARRAY_A_L)` (min 1)  column index of `out_data`.
- `out_last`  out  1  high with `out_valid` on element [W_W-1][A_L-1].
- `busy`  out  1  high while a frame is held or streaming.
- `overrun`  out  1  sticky: a result frame was dropped.
- `clear_overrun`  in  1  synchronous clear of `overrun`.
- `frame_count`  out  16  frames fully drained, wraps at 0xFFFF->0.

## Operation
- Edge detect: `comp_ready_d` register (reset 0); capture event `cap = comp_ready & ~comp_ready_d`. `comp_ready` high on the first cycle after reset counts as an edge.
- Buffer: full `ARRAY_W_W x ARRAY_A_L` register copy of `in_data`, loaded only on an accepted capture; `in_data` may change freely afterwards.
- FSM states IDLE, STREAM.
  - IDLE: `cap` -> load buffer, row=col=0, go STREAM.
  - STREAM: `out_valid`=1, `out_data`=buf[row][col]. On beat (`out_valid & out_ready`): col+1; at col=A_L-1 col->0, row+1. Beat with `out_last` -> `frame_count`+1, go IDLE.
- `cap` in STREAM, not on the last beat: frame dropped, buffer untouched, `overrun` set.
- `cap` coinciding with the last beat: new frame captured, `frame_count` increments, row=col=0, stay STREAM (no bubble, no overrun).
- `clear_overrun` with a simultaneous dropping `cap`: set wins, `overrun` stays 1.
- `busy` = (state == STREAM).
- Widths: indices saturate-free by construction; no arithmetic on data, pass-through only.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `busy`=0, `overrun`=0, `frame_count`=0, buffer=0, state IDLE.
- Capture latency: `cap` in cycle N -> `out_valid`=1 with element [0][0] in cycle N+1.
- Throughput: one element per cycle with `out_ready` held high; frame drains in `ARRAY_W_W*ARRAY_A_L` cycles.
- `out_data`, `out_row`, `out_col`, `out_last` held stable while `out_valid & ~out_ready`.
- `out_valid` never drops mid-frame; falls the cycle after the last beat unless a coinciding capture occurred.
- `overrun` rises the cycle after the dropping `cap`; clears the cycle after `clear_overrun`.
- Reset mid-stream: all outputs return to reset values immediately (async); frame discarded, counter cleared.

## Test plan
- Basic drain: `in_data[r][c]=16*r+c`, pulse `comp_ready`, `out_ready`=1 -> 30 beats 0x0000,0x0001..0x0005,0x0010..0x0045 with matching row/col, `out_last` on 0x0045 only, `frame_count`=1, `out_valid` low after.
- Backpressure: same data, `out_ready` toggling 1-0-0-1 pattern -> identical 30-value sequence, outputs stable during stalls, no duplicates or gaps.
- Overrun: new `comp_ready` edge at beat 10 with different `in_data` -> stream completes with original values, `overrun`=1; `clear_overrun` pulse -> 0.
- Back-to-back: second edge exactly on the last beat with `in_data[r][c]=0x100+16*r+c` -> `out_valid` stays high, next beat 0x0100, no overrun, `frame_count`=2 after both frames.
- Level vs edge: `comp_ready` held high for 50 cycles -> exactly one frame drained, `frame_count`=1.
- Reset mid-stream: assert `reset_n`=0 at beat 7 -> all outputs 0 asynchronously; after release with `comp_ready`=0, no output until a new edge.
